phy_rx_lane_sync_ctrl: RTL and testbench

Link-bring-up and word-assembly controller for the two-lane PHY receive path, between the per-lane serial-to-parallel converters and the 32-bit receive data consumer.
- Hunts for the idle/comma byte on each lane and declares per-lane lock.
- Raises link_up only when both lanes are locked.
- Packs aligned data byte pairs into 32-bit words with a valid strobe.
- Drops lock on strobe timeout or lane disagreement, and counts errors.

---
 rtl/phy_rx_lane_sync_ctrl.sv | 165 ++++++++++++++++
 tb/tb_phy_rx_lane_sync_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/phy_rx_lane_sync_ctrl.sv
// rtl/phy_rx_lane_sync_ctrl.sv - two-lane comma lock, link supervision and 32-bit word assembly
module phy_rx_lane_sync_ctrl #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int         LOCK_CNT = 4,
    parameter int         TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_byte_0,
    input  logic [7:0]  in_byte_1,
    input  logic        in_byte_valid,
    output logic [31:0] out_data32,
    output logic        out_valid,
    output logic [1:0]  lane_active,
    output logic        link_up,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } lane_state_t;

    localparam logic [3:0] LOCK_LIM = LOCK_CNT[3:0];
    localparam logic [7:0] TMO_LIM  = TIMEOUT[7:0];

    lane_state_t state_q [2];
    lane_state_t state_d [2];
    logic [3:0]  cnt_q   [2];
    logic [3:0]  cnt_d   [2];
    logic [7:0]  lane_byte [2];
    logic [1:0]  is_comma;

    logic [7:0]  tmo_q;
    logic        half_q;
    logic [15:0] hi_q;

    logic        any_active;
    logic        link_ok;
    logic        mismatch;
    logic        tmo_hit;
    logic        drop;
    logic        data_pair;
    logic        discard;
    logic        err_evt;

    assign lane_byte[0] = in_byte_0;
    assign lane_byte[1] = in_byte_1;
    assign is_comma[0]  = (in_byte_0 == COMMA);
    assign is_comma[1]  = (in_byte_1 == COMMA);

    assign lane_active[0] = (state_q[0] == ACTIVE);
    assign lane_active[1] = (state_q[1] == ACTIVE);
    assign any_active     = |lane_active;
    assign link_ok        = &lane_active;
    assign link_up        = link_ok;

    // Link-loss and word events; a timeout and a mismatch share one drop, so they count once
    assign mismatch  = link_ok & in_byte_valid & (is_comma[0] ^ is_comma[1]);
    assign tmo_hit   = any_active & ~in_byte_valid & (tmo_q == TMO_LIM - 8'd1);
    assign drop      = mismatch | tmo_hit;
    assign data_pair = link_ok & in_byte_valid & ~is_comma[0] & ~is_comma[1];
    assign discard   = link_ok & in_byte_valid & is_comma[0] & is_comma[1] & half_q;
    assign err_evt   = drop | discard;

    // Per-lane comma hunt: next state and comma count
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (drop) begin
                state_d[i] = HUNT;
                cnt_d[i]   = 4'd0;
            end else if (in_byte_valid) begin
                case (state_q[i])
                    HUNT: begin
                        if (is_comma[i]) begin
                            cnt_d[i]   = 4'd1;
                            state_d[i] = (LOCK_LIM == 4'd1) ? ACTIVE : SYNC;
                        end
                    end
                    SYNC: begin
                        if (is_comma[i]) begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                            if (cnt_q[i] + 4'd1 == LOCK_LIM) begin
                                state_d[i] = ACTIVE;
                            end
                        end else begin
                            state_d[i] = HUNT;
                            cnt_d[i]   = 4'd0;
                        end
                    end
                    ACTIVE: begin
                        state_d[i] = ACTIVE;
                    end
                    default: begin
                        state_d[i] = HUNT;
                        cnt_d[i]   = 4'd0;
                    end
                endcase
            end
        end
    end

    // Lane state and comma count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= HUNT;
                cnt_q[i]   <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Strobe-gap counter, armed only while some lane is ACTIVE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= 8'd0;
        end else if (drop || in_byte_valid || !any_active) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_q + 8'd1;
        end
    end

    // Pack two data pairs into one word; the upper half waits in hi_q until the pair completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_q     <= 1'b0;
            hi_q       <= 16'd0;
            out_data32 <= 32'd0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (drop || discard) begin
                half_q <= 1'b0;
            end else if (data_pair) begin
                if (half_q) begin
                    out_data32 <= {hi_q, lane_byte[0], lane_byte[1]};
                    out_valid  <= 1'b1;
                    half_q     <= 1'b0;
                end else begin
                    hi_q   <= {lane_byte[0], lane_byte[1]};
                    half_q <= 1'b1;
                end
            end
        end
    end

    // Saturating error counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= 8'd0;
        end else if (err_evt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_phy_rx_lane_sync_ctrl.sv
// tb/tb_phy_rx_lane_sync_ctrl.sv - scoreboard bench for phy_rx_lane_sync_ctrl
module tb_phy_rx_lane_sync_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  in_byte_0;
    logic [7:0]  in_byte_1;
    logic        in_byte_valid;
    logic [31:0] out_data32;
    logic        out_valid;
    logic [1:0]  lane_active;
    logic        link_up;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    phy_rx_lane_sync_ctrl #(
        .COMMA    (8'hBC),
        .LOCK_CNT (4),
        .TIMEOUT  (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_byte_0     (in_byte_0),
        .in_byte_1     (in_byte_1),
        .in_byte_valid (in_byte_valid),
        .out_data32    (out_data32),
        .out_valid     (out_valid),
        .lane_active   (lane_active),
        .link_up       (link_up),
        .err_cnt       (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b0, input logic [7:0] b1);
        in_byte_0     = b0;
        in_byte_1     = b1;
        in_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        in_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_byte_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lock4();
        for (int k = 0; k < 4; k++) send(8'hBC, 8'hBC);
    endtask

    // Monitor: every out_valid pulse must match the oldest expected word
    always @(negedge clk) begin
        if (reset && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h expected none", out_data32);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_data32 !== e) begin
                    errors++;
                    $display("FAIL word: got %h expected %h", out_data32, e);
                end
            end
        end
    end

    initial begin
        reset         = 1'b0;
        in_byte_0     = 8'h00;
        in_byte_1     = 8'h00;
        in_byte_valid = 1'b0;
        idle(3);
        check("rst_lane_active", 32'(lane_active), 32'h0);
        check("rst_link_up", 32'(link_up), 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data32", out_data32, 32'h0);
        reset = 1'b1;
        idle(2);

        // 1: lock after 4 comma strobes
        for (int k = 0; k < 3; k++) send(8'hBC, 8'hBC);
        check("t1_not_yet_linked", 32'(link_up), 32'h0);
        send(8'hBC, 8'hBC);
        check("t1_lane_active", 32'(lane_active), 32'h3);
        check("t1_link_up", 32'(link_up), 32'h1);
        check("t1_err_cnt", 32'(err_cnt), 32'h0);

        // 2: two words, the second on consecutive strobes
        exp_q.push_back(32'h11223344);
        send(8'h11, 8'h22);
        send(8'h33, 8'h44);
        exp_q.push_back(32'h55667788);
        send(8'h55, 8'h66);
        send(8'h77, 8'h88);
        idle(1);
        check("t2_err_cnt", 32'(err_cnt), 32'h0);
        check("t2_out_data_hold", out_data32, 32'h55667788);

        // 3: idle in the middle of a word discards the half and counts
        send(8'hAA, 8'hBB);
        send(8'hBC, 8'hBC);
        check("t3_err_cnt", 32'(err_cnt), 32'h1);
        check("t3_link_up", 32'(link_up), 32'h1);
        exp_q.push_back(32'h01020304);
        send(8'h01, 8'h02);
        send(8'h03, 8'h04);

        // 4: lane mismatch drops the link
        send(8'hBC, 8'h12);
        check("t4_link_up", 32'(link_up), 32'h0);
        check("t4_lane_active", 32'(lane_active), 32'h0);
        check("t4_err_cnt", 32'(err_cnt), 32'h2);
        lock4();
        check("t4_relock", 32'(link_up), 32'h1);

        // 5: strobe gap just under and at the timeout
        idle(15);
        send(8'hBC, 8'hBC);
        check("t5_gap15_link_up", 32'(link_up), 32'h1);
        check("t5_gap15_err_cnt", 32'(err_cnt), 32'h2);
        idle(15);
        check("t5_idle15_link_up", 32'(link_up), 32'h1);
        idle(1);
        check("t5_timeout_link_up", 32'(link_up), 32'h0);
        check("t5_timeout_lane_active", 32'(lane_active), 32'h0);
        check("t5_timeout_err_cnt", 32'(err_cnt), 32'h3);

        // 6: one lane loses its hunt, then async reset mid-word
        for (int k = 0; k < 3; k++) send(8'hBC, 8'hBC);
        send(8'h5A, 8'hBC);
        check("t6_lane_active", 32'(lane_active), 32'h2);
        check("t6_link_up", 32'(link_up), 32'h0);
        check("t6_err_cnt", 32'(err_cnt), 32'h3);
        lock4();
        check("t6_relink", 32'(link_up), 32'h1);
        send(8'h12, 8'h34);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_lane_active", 32'(lane_active), 32'h0);
        check("t6_rst_link_up", 32'(link_up), 32'h0);
        check("t6_rst_err_cnt", 32'(err_cnt), 32'h0);
        check("t6_rst_out_valid", 32'(out_valid), 32'h0);
        check("t6_rst_out_data32", out_data32, 32'h0);
        idle(2);
        reset = 1'b1;
        idle(1);
        lock4();
        exp_q.push_back(32'h56789ABE);
        send(8'h56, 8'h78);
        send(8'h9A, 8'hBE);
        idle(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
